gf_exp_ctrl: RTL and testbench

- Sequencer that computes GF(2^3) exponentiation result = base^exp using left-to-right square-and-multiply.
- Owns no multiplier. It time-shares one external MontMult instance through mul_a/mul_b/mul_g.
- Field polynomial is the multiplier's: P(x) = x^3 + x^2 + 1.
- Sits between a requester (start/done handshake) and the field-multiply datapath.

---
 rtl/gf_exp_ctrl_if.sv | 26 ++
 rtl/gf_exp_ctrl.sv | 127 ++++++++++++
 tb/tb_gf_exp_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/gf_exp_ctrl_if.sv
// Request/response and multiplier-port bundle for gf_exp_ctrl.
// The master side is the requester plus the external field multiplier; the slave side is the controller.
interface gf_exp_ctrl_if #(
   parameter int N = 3,
   parameter int E = 4
);
   logic         start;
   logic [N-1:0] base;
   logic [E-1:0] exp;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic [N-1:0] mul_a;
   logic [N-1:0] mul_b;
   logic [N-1:0] mul_g;

   modport master (
      output start, base, exp, mul_g,
      input  busy, done, result, mul_a, mul_b
   );

   modport slave (
      input  start, base, exp, mul_g,
      output busy, done, result, mul_a, mul_b
   );
endinterface

// File: rtl/gf_exp_ctrl.sv
// gf_exp_ctrl: base^exp in GF(2^3) by left-to-right square-and-multiply, time-sharing an external
// combinational field multiplier. Optional macro GF_EXP_EARLY_OUT_EN short-circuits exp=0 / base=0.
module gf_exp_ctrl #(
   parameter int N = 3,
   parameter int E = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   gf_exp_ctrl_if.slave    bus
);
   localparam int IW = (E > 1) ? $clog2(E) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SQR  = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        r_state, w_next;
   logic [N-1:0]  r_acc, w_acc;
   logic [N-1:0]  r_base_q, w_base_q;
   logic [E-1:0]  r_exp_q, w_exp_q;
   logic [IW-1:0] r_idx, w_idx;
   logic [N-1:0]  r_result, w_result;
   logic [N-1:0]  w_mul_a, w_mul_b;
   logic          w_bit, w_last;

   assign w_bit  = r_exp_q[r_idx];
   assign w_last = (r_idx == '0);

   // NOTE: async active-low reset in the sensitivity list, so state clears without waiting for clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values of the others.
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_base_q <= '0;
         r_exp_q  <= '0;
         r_idx    <= '0;
         r_result <= '0;
      end else begin
         r_acc    <= w_acc;
         r_base_q <= w_base_q;
         r_exp_q  <= w_exp_q;
         r_idx    <= w_idx;
         r_result <= w_result;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path leaves a variable unassigned (no latches).
      w_next   = r_state;
      w_acc    = r_acc;
      w_base_q = r_base_q;
      w_exp_q  = r_exp_q;
      w_idx    = r_idx;
      w_result = r_result;
      w_mul_a  = '0;
      w_mul_b  = '0;

      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_base_q = bus.base;
               w_exp_q  = bus.exp;
               w_acc    = N'(1);
               w_idx    = IW'(E - 1);
               w_next   = S_SQR;
`ifdef GF_EXP_EARLY_OUT_EN
               if (bus.exp == '0 || bus.base == '0) begin
                  w_acc    = (bus.exp == '0) ? N'(1) : '0;
                  w_result = w_acc;
                  w_next   = S_DONE;
               end
`endif
            end
         end
         S_SQR: begin
            w_mul_a = r_acc;
            w_mul_b = r_acc;
            w_acc   = bus.mul_g;
            if (w_bit) begin
               w_next = S_MUL;
            end else if (w_last) begin
               w_result = bus.mul_g;
               w_next   = S_DONE;
            end else begin
               w_idx = r_idx - 1'b1;
            end
         end
         S_MUL: begin
            w_mul_a = r_acc;
            w_mul_b = r_base_q;
            w_acc   = bus.mul_g;
            // Finishing at idx=0 wins over the decrement, so idx never wraps.
            if (w_last) begin
               w_result = bus.mul_g;
               w_next   = S_DONE;
            end else begin
               w_idx  = r_idx - 1'b1;
               w_next = S_SQR;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Handshake and multiplier operands decode from registered state only.
   assign bus.busy   = (r_state != S_IDLE);
   assign bus.done   = (r_state == S_DONE);
   assign bus.result = r_result;
   assign bus.mul_a  = w_mul_a;
   assign bus.mul_b  = w_mul_b;
endmodule

// File: tb/tb_gf_exp_ctrl.sv
// Directed bench for gf_exp_ctrl: models the external GF(8) multiplier (P = x^3 + x^2 + 1)
// and checks results, done latency, multiplier trace, start handling and async reset.
module tb_gf_exp_ctrl;
   localparam int N = 3;
   localparam int E = 4;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fails;

   gf_exp_ctrl_if #(.N(N), .E(E)) bus ();

   gf_exp_ctrl #(.N(N), .E(E)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Plain polynomial product reduced by x^3 + x^2 + 1.
   function automatic logic [2:0] gf_mul(input logic [2:0] a, input logic [2:0] b);
      logic [4:0] p;
      p = '0;
      for (int i = 0; i < 3; i++)
         if (b[i]) p = p ^ ({2'b00, a} << i);
      if (p[4]) p = p ^ 5'b11010;
      if (p[3]) p = p ^ 5'b01101;
      return p[2:0];
   endfunction

   // Reference power by repeated multiplication (independent of square-and-multiply).
   function automatic logic [2:0] gf_pow(input logic [2:0] b, input logic [3:0] e);
      logic [2:0] r;
      r = 3'b001;
      for (int i = 0; i < int'(e); i++) r = gf_mul(r, b);
      return r;
   endfunction

   function automatic int exp_lat(input logic [2:0] b, input logic [3:0] e);
`ifdef GF_EXP_EARLY_OUT_EN
      if (e == '0 || b == '0) return 1;
`endif
      return E + $countones(e) + 1;
   endfunction

   assign bus.mul_g = gf_mul(bus.mul_a, bus.mul_b);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv)
      else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   logic [2:0] trace_a [16];
   logic [2:0] trace_b [16];
   logic       busy_ok;

   // Issue one request from IDLE; latency counts cycles after the accepting edge, starting at 1.
   task automatic run_op(input logic [2:0] b, input logic [3:0] e,
                         output logic [2:0] res, output int lat);
      @(negedge clk);
      bus.start = 1'b1;
      bus.base  = b;
      bus.exp   = e;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.base  = ~b;
      bus.exp   = ~e;
      lat     = 0;
      res     = 'x;
      busy_ok = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c <= 16) begin
            trace_a[c-1] = bus.mul_a;
            trace_b[c-1] = bus.mul_b;
         end
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         if (bus.done === 1'b1) begin
            lat = c;
            res = bus.result;
            break;
         end
      end
      if (lat == 0) check("done_timeout", 32'd0, 32'd1);
   endtask

   logic [2:0] res;
   int         lat;
   int         n_done;
   int         done_at [4];
   logic [2:0] exp_ta [7];
   logic [2:0] exp_tb [7];

   initial begin
      n_tests   = 0;
      n_fails   = 0;
      bus.start = 1'b0;
      bus.base  = '0;
      bus.exp   = '0;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      check("rst_busy",   32'(bus.busy),   32'd0);
      check("rst_done",   32'(bus.done),   32'd0);
      check("rst_result", 32'(bus.result), 32'd0);
      check("rst_mul_a",  32'(bus.mul_a),  32'd0);
      check("rst_mul_b",  32'(bus.mul_b),  32'd0);

      // x^3 with the full operand trace
      run_op(3'b010, 4'b0011, res, lat);
      check("t1_result", 32'(res), 32'b101);
      check("t1_lat",    32'(lat), 32'd7);
      check("t1_busy",   32'(busy_ok), 32'd1);
      exp_ta = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b000};
      exp_tb = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b000};
      for (int i = 0; i < 7; i++) begin
         check($sformatf("t1_mul_a[%0d]", i + 1), 32'(trace_a[i]), 32'(exp_ta[i]));
         check($sformatf("t1_mul_b[%0d]", i + 1), 32'(trace_b[i]), 32'(exp_tb[i]));
      end
      @(negedge clk);
      check("t1_done_pulse", 32'(bus.done),   32'd0);
      check("t1_busy_idle",  32'(bus.busy),   32'd0);
      check("t1_held",       32'(bus.result), 32'b101);

      run_op(3'b010, 4'b0111, res, lat);
      check("t2a_result", 32'(res), 32'b001);
      check("t2a_lat",    32'(lat), 32'd8);
      run_op(3'b011, 4'b0010, res, lat);
      check("t2b_result", 32'(res), 32'b101);
      check("t2b_lat",    32'(lat), 32'd6);

      run_op(3'b110, 4'b0000, res, lat);
      check("t3a_result", 32'(res), 32'b001);
      check("t3a_lat",    32'(lat), 32'(exp_lat(3'b110, 4'b0000)));
      run_op(3'b000, 4'b0101, res, lat);
      check("t3b_result", 32'(res), 32'b000);
      check("t3b_lat",    32'(lat), 32'(exp_lat(3'b000, 4'b0101)));
      run_op(3'b000, 4'b0000, res, lat);
      check("t3c_zero_pow_zero", 32'(res), 32'b001);

      // start held high; operands disturbed only while busy
      @(negedge clk);
      bus.start = 1'b1;
      bus.base  = 3'b100;
      bus.exp   = 4'b1000;
      n_done    = 0;
      for (int c = 1; c <= 21; c++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            if (n_done < 4) done_at[n_done] = c;
            n_done++;
            check($sformatf("t4_result@%0d", c), 32'(bus.result), 32'b100);
         end
         if (bus.busy === 1'b1 && bus.done !== 1'b1) begin
            bus.base = 3'b111;
            bus.exp  = 4'b0001;
         end else begin
            bus.base = 3'b100;
            bus.exp  = 4'b1000;
         end
         if (c == 21) bus.start = 1'b0;
      end
      check("t4_n_done", 32'(n_done), 32'd3);
      if (n_done == 3) begin
         check("t4_first",  32'(done_at[0]), 32'd6);
         check("t4_gap1",   32'(done_at[1] - done_at[0]), 32'd7);
         check("t4_gap2",   32'(done_at[2] - done_at[1]), 32'd7);
      end
      @(negedge clk);
      check("t4_idle_after", 32'(bus.busy), 32'd0);

      // async reset in the middle of a run
      @(negedge clk);
      bus.start = 1'b1;
      bus.base  = 3'b010;
      bus.exp   = 4'b1111;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("t5_busy_before", 32'(bus.busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_busy",   32'(bus.busy),   32'd0);
      check("t5_done",   32'(bus.done),   32'd0);
      check("t5_result", 32'(bus.result), 32'd0);
      check("t5_mul_a",  32'(bus.mul_a),  32'd0);
      check("t5_mul_b",  32'(bus.mul_b),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(3'b111, 4'b0001, res, lat);
      check("t5_result_after", 32'(res), 32'b111);
      check("t5_lat_after",    32'(lat), 32'd6);

      // every base and exponent against the reference model
      for (int b = 0; b < 8; b++) begin
         for (int e = 0; e < 16; e++) begin
            run_op(3'(b), 4'(e), res, lat);
            check($sformatf("t6_result b=%0d e=%0d", b, e), 32'(res), 32'(gf_pow(3'(b), 4'(e))));
            check($sformatf("t6_lat b=%0d e=%0d", b, e), 32'(lat), 32'(exp_lat(3'(b), 4'(e))));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
      $finish;
   end
endmodule
